// File: rtl/switch_poll_controller.sv
// Switch PIO poller / debouncer. Periodically reads the switch PIO data register, requires
// DEBOUNCE identical consecutive samples before accepting a new value, and keeps the
// debounced state, sticky per-bit change flags and a level interrupt behind a 4-word CSR.
module switch_poll_controller #(
  parameter int unsigned WIDTH          = 10,
  parameter int unsigned CNT_W          = 20,
  parameter int unsigned DEBOUNCE       = 4,
  parameter int unsigned DEFAULT_PERIOD = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  pio_address,
  input  logic [31:0] pio_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_ADDR    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_UPDATE  = 3'd4;

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             irq_en_q, irq_en_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [3:0]       stable_q, stable_d;
  logic [WIDTH-1:0] sw_state_q, sw_state_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic             irq_q, irq_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             wr_ctrl, wr_period, wr_edge;
  logic [WIDTH-1:0] wmask, newchg, cand_upd;
  logic [3:0]       stable_upd;
  logic             accept, do_update;
  logic             unused_bits;

  assign unused_bits = ^{pio_readdata, s_writedata};

  assign wr_ctrl   = s_write && (s_address == 2'd0);
  assign wr_period = s_write && (s_address == 2'd1);
  assign wr_edge   = s_write && (s_address == 2'd3);

  // Next CSR values; the FSM and irq react to a CTRL write in the same cycle it is written.
  always_comb begin
    en_d     = wr_ctrl ? s_writedata[0] : en_q;
    irq_en_d = wr_ctrl ? s_writedata[1] : irq_en_q;
    period_d = wr_period ? s_writedata[CNT_W-1:0] : period_q;
    wmask    = wr_edge ? s_writedata[WIDTH-1:0] : '0;
  end

  // Debounce step evaluated on the captured sample.
  always_comb begin
    if (sample_q == cand_q) begin
      cand_upd   = cand_q;
      stable_upd = (stable_q >= DEB) ? DEB : stable_q + 4'd1;
    end else begin
      cand_upd   = sample_q;
      stable_upd = 4'd1;
    end
    accept    = (stable_upd == DEB) && (cand_upd != sw_state_q);
    do_update = en_d && (state_q == S_UPDATE);
    newchg    = (do_update && accept) ? (sw_state_q ^ cand_upd) : '0;
  end

  // Sampling FSM next state; disable forces IDLE and clears the debounce history.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sample_d   = sample_q;
    cand_d     = cand_q;
    stable_d   = stable_q;
    sw_state_d = sw_state_q;
    if (!en_d) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      cand_d   = '0;
      stable_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT;
          cnt_d   = period_q;
        end
        S_WAIT: begin
          if (cnt_q == '0) state_d = S_ADDR;
          else             cnt_d   = cnt_q - 1'b1;
        end
        S_ADDR:    state_d = S_CAPTURE;
        S_CAPTURE: begin
          sample_d = pio_readdata[WIDTH-1:0];
          state_d  = S_UPDATE;
        end
        S_UPDATE: begin
          cand_d   = cand_upd;
          stable_d = stable_upd;
          if (accept) sw_state_d = cand_upd;
          state_d = S_WAIT;
          cnt_d   = period_q;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Sticky change flags (a new change beats a simultaneous clear), irq and read mux.
  always_comb begin
    edge_d  = (edge_q & ~wmask) | newchg;
    irq_d   = irq_en_d & (|edge_d);
    rdata_d = rdata_q;
    if (s_read) begin
      rdata_d = '0;
      case (s_address)
        2'd0: rdata_d[1:0]       = {irq_en_q, en_q};
        2'd1: rdata_d[CNT_W-1:0] = period_q;
        2'd2: rdata_d[WIDTH-1:0] = sw_state_q;
        default: rdata_d[WIDTH-1:0] = edge_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      period_q   <= CNT_W'(DEFAULT_PERIOD);
      sample_q   <= '0;
      cand_q     <= '0;
      stable_q   <= '0;
      sw_state_q <= '0;
      edge_q     <= '0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      period_q   <= period_d;
      sample_q   <= sample_d;
      cand_q     <= cand_d;
      stable_q   <= stable_d;
      sw_state_q <= sw_state_d;
      edge_q     <= edge_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
    end
  end

  assign pio_address = ((state_q == S_ADDR) || (state_q == S_CAPTURE)) ? 2'b00 : 2'b11;
  assign s_readdata  = rdata_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_switch_poll_controller.sv
// Bench for switch_poll_controller: behavioural switch PIO, CSR table vectors and
// hand-written timing sequences, with CSR read results checked through a scoreboard queue.
module tb_switch_poll_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  pio_address;
  logic [31:0] pio_readdata = '0;
  logic [1:0]  s_address = '0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic        irq;

  logic [9:0]  in_port = '0;
  logic        bounce_en = 1'b0;
  logic        bounce_bit = 1'b1;
  logic [1:0]  addr_prev = 2'b11;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[9];

  switch_poll_controller dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pio_address  (pio_address),
    .pio_readdata (pio_readdata),
    .s_address    (s_address),
    .s_read       (s_read),
    .s_write      (s_write),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  // PIO model: registered readdata, address 0 is the switch data, others read 0. In bounce
  // mode the switch value toggles after every completed capture.
  always @(posedge clk) begin
    if (pio_address == 2'b00)
      pio_readdata <= {22'b0, (bounce_en ? {9'b0, bounce_bit} : in_port)};
    else
      pio_readdata <= '0;
    if (bounce_en && pio_address == 2'b00 && addr_prev == 2'b00) bounce_bit <= ~bounce_bit;
    addr_prev <= pio_address;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All CSR tasks start at a negedge and return at the following negedge.
  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_write = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_write = 1'b0;
  endtask

  task automatic csr_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    sb_t e;
    sb_q.push_back('{name: name, exp: exp});
    s_address = a; s_read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_read = 1'b0;
    e = sb_q.pop_front();
    check(e.name, s_readdata, e.exp);
  endtask

  initial begin
    logic seen;
    vecs[0] = '{wr: 1'b0, addr: 2'd0, data: 32'h0,        exp: 32'h0};
    vecs[1] = '{wr: 1'b0, addr: 2'd1, data: 32'h0,        exp: 32'd50000};
    vecs[2] = '{wr: 1'b0, addr: 2'd2, data: 32'h0,        exp: 32'h0};
    vecs[3] = '{wr: 1'b0, addr: 2'd3, data: 32'h0,        exp: 32'h0};
    vecs[4] = '{wr: 1'b1, addr: 2'd1, data: 32'hFFFFFFFF, exp: 32'h000FFFFF};
    vecs[5] = '{wr: 1'b1, addr: 2'd0, data: 32'hFFFFFFFC, exp: 32'h0};
    vecs[6] = '{wr: 1'b1, addr: 2'd2, data: 32'h3FF,      exp: 32'h0};
    vecs[7] = '{wr: 1'b1, addr: 2'd3, data: 32'h3FF,      exp: 32'h0};
    vecs[8] = '{wr: 1'b1, addr: 2'd1, data: 32'h0,        exp: 32'h0};

    repeat (3) @(negedge clk);
    check("rst_pio_address", {30'b0, pio_address}, 32'h3);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_readdata", s_readdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr) csr_write(vecs[i].addr, vecs[i].data);
      csr_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Simultaneous read and write returns the old value; readdata then holds.
    s_address = 2'd1; s_writedata = 32'd7; s_read = 1'b1; s_write = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_read = 1'b0; s_write = 1'b0;
    check("rw_same_cycle_old", s_readdata, 32'h0);
    csr_read(2'd1, 32'd7, "rw_new_value");
    @(negedge clk);
    check("readdata_hold", s_readdata, 32'd7);
    csr_write(2'd1, 32'd0);

    // Bounce rejection: alternating samples never settle.
    bounce_en = 1'b1;
    csr_write(2'd0, 32'h1);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      seen |= irq;
    end
    check("bounce_irq_never", {31'b0, seen}, 32'h0);
    csr_read(2'd2, 32'h0, "bounce_state");
    csr_read(2'd3, 32'h0, "bounce_edge");
    csr_write(2'd0, 32'h0);
    bounce_en = 1'b0;

    // Basic accept with PERIOD=0: samples every 4 cycles, accept after 4th sample.
    in_port = 10'h005;
    csr_write(2'd0, 32'h3);
    for (int n = 1; n <= 17; n++) begin
      check($sformatf("accept_addr_n%0d", n), {30'b0, pio_address},
            ((n % 4 == 2) || (n % 4 == 3)) ? 32'h0 : 32'h3);
      if (n == 16) check("accept_irq_before", {31'b0, irq}, 32'h0);
      if (n == 17) check("accept_irq_after", {31'b0, irq}, 32'h1);
      @(negedge clk);
    end
    csr_read(2'd2, 32'h005, "accept_state");
    csr_read(2'd3, 32'h005, "accept_edge");

    // W1C of bit 0 in the same cycle as an acceptance that changes bit 0 again.
    csr_write(2'd0, 32'h0);
    in_port = 10'h004;
    csr_write(2'd0, 32'h3);
    repeat (15) @(negedge clk);
    csr_write(2'd3, 32'h1);
    check("race_irq", {31'b0, irq}, 32'h1);
    csr_read(2'd3, 32'h005, "race_edge");
    csr_read(2'd2, 32'h004, "race_state");

    // irq masking.
    csr_write(2'd0, 32'h0);
    csr_write(2'd3, 32'h3FF);
    in_port = 10'h204;
    csr_write(2'd0, 32'h1);
    repeat (16) @(negedge clk);
    check("mask_irq_off", {31'b0, irq}, 32'h0);
    csr_read(2'd3, 32'h200, "mask_edge");
    csr_write(2'd0, 32'h3);
    check("mask_irq_on", {31'b0, irq}, 32'h1);
    csr_write(2'd3, 32'h200);
    check("mask_irq_cleared", {31'b0, irq}, 32'h0);
    csr_read(2'd3, 32'h0, "mask_edge_cleared");

    // Disable in the middle of a PERIOD=100 countdown, then re-enable.
    csr_write(2'd0, 32'h0);
    csr_write(2'd1, 32'd100);
    csr_write(2'd0, 32'h1);
    repeat (50) @(negedge clk);
    csr_write(2'd0, 32'h0);
    check("disable_addr", {30'b0, pio_address}, 32'h3);
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      seen |= (pio_address == 2'b00);
    end
    check("disable_no_sample", {31'b0, seen}, 32'h0);
    csr_read(2'd2, 32'h204, "disable_state");
    csr_read(2'd3, 32'h0, "disable_edge");
    csr_read(2'd2, 32'h204, "pre_reset_read");
    csr_write(2'd0, 32'h1);
    repeat (100) @(negedge clk);
    check("reenable_wait_end", {30'b0, pio_address}, 32'h3);
    @(negedge clk);
    check("reenable_addr", {30'b0, pio_address}, 32'h0);
    @(negedge clk);
    check("reenable_capture", {30'b0, pio_address}, 32'h0);

    // Asynchronous reset during CAPTURE.
    #2 reset_n = 1'b0;
    #1;
    check("midrst_pio_address", {30'b0, pio_address}, 32'h3);
    check("midrst_readdata", s_readdata, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      csr_read(vecs[i].addr, vecs[i].exp, $sformatf("post_reset%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_poll_controller.md
# switch_poll_controller

Autonomous sampler and debouncer for the 10-bit switch PIO. It drives the PIO's address/readdata port on a programmable period, filters contact bounce, and keeps a debounced switch state plus sticky per-bit change flags. It raises a level interrupt to the HPS, which configures and reads the block through a small Avalon-MM slave instead of polling the raw PIO.

## Interface
- WIDTH, 10: number of switch bits sampled (bits [WIDTH-1:0] of PIO readdata).
- CNT_W, 20: width of the sample-period counter.
- DEBOUNCE, 4: consecutive identical samples required to accept a new value (2..15).
- DEFAULT_PERIOD, 50000: reset value of the PERIOD register.

- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- pio_address  out  2  address to switch PIO; 2'b00 = data register.
- pio_readdata  in  32  PIO readdata; registered in the PIO, valid 1 cycle after pio_address is applied.
- s_address  in  2  CSR word address.
- s_read  in  1  CSR read strobe.
- s_write  in  1  CSR write strobe.
- s_writedata  in  32  CSR write data.
- s_readdata  out  32  CSR read data, registered, read latency 1.
- irq  out  1  level interrupt, registered.

## Operation
- CSR map (unused bits read 0, writes ignored):
  - 0 CTRL: bit0 enable, bit1 irq_en. R/W.
  - 1 PERIOD: [CNT_W-1:0]. R/W.
  - 2 STATE: [WIDTH-1:0] debounced switches. Read-only.
  - 3 EDGE: [WIDTH-1:0] sticky changed bits. Write-1-to-clear.
- FSM states: IDLE, WAIT, ADDR, CAPTURE, UPDATE.
  - IDLE: pio_address = 2'b11. Moves to WAIT when enable = 1, loading cnt = PERIOD.
  - WAIT: decrements cnt. Moves to ADDR when cnt == 0, so WAIT lasts PERIOD+1 cycles.
  - ADDR: pio_address = 2'b00.
  - CAPTURE: pio_address = 2'b00; sample <= pio_readdata[WIDTH-1:0].
  - UPDATE: runs the debounce step, then returns to WAIT reloading cnt = PERIOD.
  - Outside ADDR/CAPTURE, pio_address = 2'b11 (unmapped, reads 0).
- Debounce step:
  - If sample == cand, stable <= min(stable+1, DEBOUNCE). Otherwise cand <= sample and stable <= 1.
  - Acceptance: when the updated stable == DEBOUNCE and cand != STATE:
    - EDGE <= EDGE | (STATE ^ cand);
    - STATE <= cand.
- EDGE update with simultaneous W1C: EDGE <= (EDGE & ~wmask) | newchg. A newly set bit always wins over a clear.
- irq <= irq_en & (|EDGE_next).
- enable cleared in any state: next state is IDLE; cnt, cand and stable reset to 0. STATE and EDGE are retained.
- PERIOD written during WAIT takes effect at the next reload, not the current countdown.

## Timing
- Reset values:
  - pio_address 2'b11; s_readdata 0; irq 0.
  - CTRL 0; PERIOD DEFAULT_PERIOD; STATE 0; EDGE 0.
  - cand 0; stable 0; FSM in IDLE.
- Sample interval is PERIOD+4 cycles (WAIT PERIOD+1, ADDR, CAPTURE, UPDATE).
- First sample after enable:
  - enable write at cycle T;
  - WAIT begins at T+1;
  - ADDR at T+PERIOD+2;
  - capture at T+PERIOD+3.
- STATE, EDGE and irq change in the cycle after UPDATE.
- CSR access:
  - Read data is valid the cycle after s_read; s_readdata holds its value otherwise.
  - A write takes effect the cycle after s_write.
  - Simultaneous s_read and s_write: the read returns the old value.
- Asynchronous reset mid-sample aborts immediately. No partial update reaches STATE or EDGE.

## Test plan
- Basic accept: PERIOD=0, DEBOUNCE=4, CTRL=3, in_port 0x000→0x005 held.
  - STATE=0x005 after the 4th sample.
  - EDGE=0x005; irq=1.
  - Samples occur every 4 cycles.
- Bounce rejection: in_port alternates 0x001/0x000 on every sample for 20 samples.
  - STATE stays 0x000; EDGE stays 0; irq stays 0.
- W1C race: EDGE=0x005, then write EDGE=0x001 in the same cycle as an acceptance that flips bit 0 again.
  - EDGE=0x005 (bit 0 re-set, bit 2 kept); irq stays 1.
- irq masking:
  - irq_en=0 with EDGE=0x200 → irq=0.
  - Set irq_en → irq=1 the next cycle.
  - W1C 0x200 → irq=0.
- Disable mid-WAIT: clear enable with PERIOD=100 at cnt=50.
  - IDLE the next cycle; pio_address=2'b11.
  - STATE and EDGE unchanged.
  - Re-enable → first ADDR occurs PERIOD+2 cycles after the write.
- Reset mid-CAPTURE: assert reset_n=0.
  - All outputs and registers return to their reset values immediately.
  - PERIOD reads back DEFAULT_PERIOD.
